// File: rtl/combo_lock_pkg.sv
// Shared types and width helpers for the parametrised combination lock.
//   lock_state_e : top-level lock FSM states
//   idx_width    : width of the digit index / progress counter
//   fail_width   : width of the consecutive-failure counter
//   timer_width  : width of the lockout cycle counter
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_e;

  // Counters are never narrower than one bit, even for degenerate parameters.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned idx_width(input int unsigned seq_len);
    return clog2_min1(seq_len + 1);
  endfunction

  function automatic int unsigned fail_width(input int unsigned max_tries);
    return clog2_min1(max_tries + 1);
  endfunction

  function automatic int unsigned timer_width(input int unsigned lockout_cyc);
    return clog2_min1(lockout_cyc);
  endfunction

endpackage

// File: rtl/combo_lockout_timer.sv
// Fixed-length busy window, started by a one-cycle pulse.
//   CLK   : clock, rising edge
//   RST   : synchronous reset, active-low
//   start : begin a window (ignored while busy)
//   busy  : registered, high for exactly LOCKOUT_CYC cycles after start
//   done  : high during the final busy cycle (terminal count)
module combo_lockout_timer
  import combo_lock_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYC = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned TMR_W = timer_width(LOCKOUT_CYC);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(LOCKOUT_CYC - 1);

  logic [TMR_W-1:0] cnt_q;

  // Terminal count is flagged in the last busy cycle so the owner can leave
  // its waiting state on the same edge that busy falls.
  assign done = busy && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (busy) begin
      if (cnt_q == LAST) begin
        busy  <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + TMR_W'(1);
      end
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised multi-digit combination lock with run-time reprogramming.
//   CLK, RST    : clock (rising edge) and synchronous active-low reset
//   code_in     : entered digit, sampled while code_valid is high
//   code_valid  : one-cycle digit strobe
//   lock_cmd    : relock request (UNLOCKED only, beats prog_en)
//   prog_en     : enter/hold programming mode (entered from UNLOCKED only)
//   unlocked    : high in UNLOCKED and PROGRAM
//   alarm       : high for the LOCKOUT_CYC cycles of lockout
//   prog_active : high in PROGRAM
//   fail_pulse  : one-cycle pulse per rejected sequence
//   progress    : digits accepted so far in the current entry/program sequence
module combo_lock_param
  import combo_lock_pkg::*;
#(
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned SEQ_LEN     = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_CYC = 16,
  parameter logic [SEQ_LEN*CODE_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CODE_W-1:0]            code_in,
  input  logic                         code_valid,
  input  logic                         lock_cmd,
  input  logic                         prog_en,
  output logic                         unlocked,
  output logic                         alarm,
  output logic                         prog_active,
  output logic                         fail_pulse,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress
);

  localparam int unsigned CODE_BITS = SEQ_LEN * CODE_W;
  localparam int unsigned IDX_W     = idx_width(SEQ_LEN);
  localparam int unsigned FAIL_W    = fail_width(MAX_TRIES);

  lock_state_e           state_q;
  logic [CODE_BITS-1:0]  stored_q;
  logic [CODE_BITS-1:0]  shadow_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  mismatch_q;
  logic [FAIL_W-1:0]     fail_cnt_q;
  logic                  unlocked_q;
  logic                  prog_active_q;
  logic                  fail_pulse_q;

  logic [CODE_W-1:0]     exp_digit;
  logic [CODE_BITS-1:0]  shadow_wr;
  logic [FAIL_W-1:0]     fail_cnt_inc;
  logic                  is_last;
  logic                  miss_now;
  logic                  lockout_start;
  logic                  tmr_busy;
  logic                  tmr_done;

  // Stored digit at idx, and the shadow with code_in merged at idx
  // (digit 0 lives in the MSBs).
  always_comb begin
    exp_digit = '0;
    shadow_wr = shadow_q;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        exp_digit = stored_q[(SEQ_LEN-1-i)*CODE_W +: CODE_W];
        shadow_wr[(SEQ_LEN-1-i)*CODE_W +: CODE_W] = code_in;
      end
    end
  end

  assign is_last      = (idx_q == IDX_W'(SEQ_LEN - 1));
  // Sticky mismatch including the digit being sampled now; never reveals
  // which digit was wrong.
  assign miss_now     = mismatch_q | (code_in != exp_digit);
  assign fail_cnt_inc = (fail_cnt_q == FAIL_W'(MAX_TRIES)) ? fail_cnt_q
                                                           : fail_cnt_q + FAIL_W'(1);
  assign lockout_start = (state_q == ENTRY) && code_valid && is_last && miss_now &&
                         (fail_cnt_inc == FAIL_W'(MAX_TRIES));

  // Alarm is the timer's busy flop: high exactly while the lockout runs.
  combo_lockout_timer #(
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .start(lockout_start),
    .busy (tmr_busy),
    .done (tmr_done)
  );

  // Lock FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ENTRY;
      stored_q      <= DEFAULT_CODE;
      shadow_q      <= '0;
      idx_q         <= '0;
      mismatch_q    <= 1'b0;
      fail_cnt_q    <= '0;
      unlocked_q    <= 1'b0;
      prog_active_q <= 1'b0;
      fail_pulse_q  <= 1'b0;
    end else begin
      fail_pulse_q <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (code_valid) begin
            if (is_last) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (!miss_now) begin
                state_q    <= UNLOCKED;
                unlocked_q <= 1'b1;
                fail_cnt_q <= '0;
              end else begin
                fail_pulse_q <= 1'b1;
                fail_cnt_q   <= fail_cnt_inc;
                if (lockout_start) begin
                  state_q <= LOCKOUT;
                end
              end
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              mismatch_q <= miss_now;
            end
          end
        end

        UNLOCKED: begin
          if (lock_cmd) begin
            state_q    <= ENTRY;
            unlocked_q <= 1'b0;
            idx_q      <= '0;
          end else if (prog_en) begin
            state_q       <= PROGRAM;
            prog_active_q <= 1'b1;
            shadow_q      <= '0;
            idx_q         <= '0;
          end
        end

        PROGRAM: begin
          if (!prog_en) begin
            // Abort: shadow is discarded, stored code untouched.
            state_q       <= UNLOCKED;
            prog_active_q <= 1'b0;
            shadow_q      <= '0;
            idx_q         <= '0;
          end else if (code_valid) begin
            if (is_last) begin
              // Atomic commit on the exit edge, including the final digit.
              stored_q      <= shadow_wr;
              shadow_q      <= '0;
              idx_q         <= '0;
              state_q       <= ENTRY;
              unlocked_q    <= 1'b0;
              prog_active_q <= 1'b0;
            end else begin
              shadow_q <= shadow_wr;
              idx_q    <= idx_q + IDX_W'(1);
            end
          end
        end

        LOCKOUT: begin
          if (tmr_done) begin
            state_q    <= ENTRY;
            fail_cnt_q <= '0;
          end
        end

        default: state_q <= ENTRY;
      endcase
    end
  end

  assign unlocked    = unlocked_q;
  assign alarm       = tmr_busy;
  assign prog_active = prog_active_q;
  assign fail_pulse  = fail_pulse_q;
  // idx is cleared on every exit from ENTRY/PROGRAM, so it reads 0 elsewhere.
  assign progress    = idx_q;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed scoreboard bench for combo_lock_param at default parameters.
module tb_combo_lock_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] code_in;
  logic       code_valid;
  logic       lock_cmd;
  logic       prog_en;
  logic       unlocked;
  logic       alarm;
  logic       prog_active;
  logic       fail_pulse;
  logic [2:0] progress;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       unl;
    logic       alm;
    logic       prg;
    logic       fp;
    logic [2:0] pr;
  } exp_t;

  exp_t sb[$];

  combo_lock_param dut (
    .CLK        (CLK),
    .RST        (RST),
    .code_in    (code_in),
    .code_valid (code_valid),
    .lock_cmd   (lock_cmd),
    .prog_en    (prog_en),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .prog_active(prog_active),
    .fail_pulse (fail_pulse),
    .progress   (progress)
  );

  always #5 CLK = ~CLK;

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (unlocked === e.unl) else begin
        bad++; $error("FAIL %s.unlocked got=%0b want=%0b", e.tag, unlocked, e.unl);
      end
      total++;
      assert (alarm === e.alm) else begin
        bad++; $error("FAIL %s.alarm got=%0b want=%0b", e.tag, alarm, e.alm);
      end
      total++;
      assert (prog_active === e.prg) else begin
        bad++; $error("FAIL %s.prog_active got=%0b want=%0b", e.tag, prog_active, e.prg);
      end
      total++;
      assert (fail_pulse === e.fp) else begin
        bad++; $error("FAIL %s.fail_pulse got=%0b want=%0b", e.tag, fail_pulse, e.fp);
      end
      total++;
      assert (progress === e.pr) else begin
        bad++; $error("FAIL %s.progress got=%0d want=%0d", e.tag, progress, e.pr);
      end
    end
  endtask

  // One clock: drive inputs, push expected post-edge outputs, compare after edge.
  task automatic step(input string tag, input logic cv, input logic [3:0] d,
                      input logic lk, input logic pe,
                      input logic eu, input logic ea, input logic ep,
                      input logic ef, input logic [2:0] epr);
    exp_t e;
    e.tag = tag; e.unl = eu; e.alm = ea; e.prg = ep; e.fp = ef; e.pr = epr;
    sb.push_back(e);
    code_valid = cv;
    code_in    = d;
    lock_cmd   = lk;
    prog_en    = pe;
    @(posedge CLK);
    #1;
    check_out();
  endtask

  // Enter a full 4-digit sequence from ENTRY.
  task automatic enter4(input string tag, input logic [15:0] code,
                        input logic ok, input logic to_lockout);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = code[4*(3-i) +: 4];
      if (i < 3) step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i + 1));
      else       step(tag, 1'b1, d, 1'b0, 1'b0, ok, to_lockout, 1'b0, !ok, 3'd0);
    end
  endtask

  // Program a new 4-digit code from PROGRAM with prog_en held.
  task automatic prog4(input string tag, input logic [15:0] code);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = code[4*(3-i) +: 4];
      if (i < 3) step(tag, 1'b1, d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'(i + 1));
      else       step(tag, 1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    end
  endtask

  initial begin
    RST = 1'b0; code_in = '0; code_valid = 1'b0; lock_cmd = 1'b0; prog_en = 1'b0;
    step("reset",  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step("reset2", 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    RST = 1'b1;
    step("idle",   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Correct entry, then code_valid ignored while unlocked, then relock.
    enter4("ok1", 16'h1234, 1'b1, 1'b0);
    step("unl_hold",   1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("unl_cv_ign", 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("relock1",    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Wrong middle digit judged only at the end; success clears fail count.
    enter4("miss1", 16'h1934, 1'b0, 1'b0);
    step("fp_one_cycle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    enter4("ok_after_miss", 16'h1234, 1'b1, 1'b0);
    step("relock2", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    enter4("miss_a", 16'h4321, 1'b0, 1'b0);
    enter4("miss_b", 16'h4321, 1'b0, 1'b0);
    enter4("ok_cnt_cleared", 16'h1234, 1'b1, 1'b0);
    step("relock3", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Lockout: 16 alarm cycles, all inputs ignored meanwhile.
    enter4("lk_miss1", 16'h4321, 1'b0, 1'b0);
    enter4("lk_miss2", 16'h4321, 1'b0, 1'b0);
    enter4("lk_miss3", 16'h4321, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step("lock_hold", 1'b1, 4'((i % 4) + 1), i[0], i[1],
           1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    end
    step("alarm_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    enter4("ok_post_lock", 16'h1234, 1'b1, 1'b0);

    // Program abort, lock_cmd ignored in PROGRAM, lock_cmd beats prog_en.
    step("prog_enter", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    step("prog_lk_ign", 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    step("prog_d1",    1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    step("prog_abort", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("lk_prio",    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    enter4("ok_after_abort", 16'h1234, 1'b1, 1'b0);

    // Reprogram to A,B,C,D: relocks, old code fails, new code unlocks.
    step("prog_enter2", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    prog4("prog_abcd", 16'hABCD);
    enter4("old_code", 16'h1234, 1'b0, 1'b0);
    enter4("new_code", 16'hABCD, 1'b1, 1'b0);
    step("relock4", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Lockout with the old code, reset mid-lockout restores the default.
    enter4("lk2_miss1", 16'h1234, 1'b0, 1'b0);
    enter4("lk2_miss2", 16'h1234, 1'b0, 1'b0);
    enter4("lk2_miss3", 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("lock2_hold", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    end
    RST = 1'b0;
    step("rst_mid_lock", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    RST = 1'b1;
    enter4("ok_default", 16'h1234, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
